// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared RC4 types and constants for the KSA and later PRGA stages
package rc4_pkg;

  localparam int S_SIZE  = 256;
  localparam int KEY_LEN = 3;
  localparam int KEY_W   = 24;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    RD_I,
    WT_I,
    CALC_J,
    RD_J,
    WT_J,
    WR_I,
    WR_J,
    DONE
  } state_t;

endpackage

// File: rtl/rc4_ksa_sequencer.sv
// rtl/rc4_ksa_sequencer.sv - drives s_memory through identity fill and the RC4 key-scheduling swap loop
module rc4_ksa_sequencer
  import rc4_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [KEY_W-1:0] secret_key,
  input  byte_t            q,
  output byte_t            address,
  output byte_t            data,
  output logic             wren,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  byte_t            i_q, i_d;
  byte_t            j_q, j_d;
  byte_t            si_q, si_d;
  byte_t            sj_q, sj_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [1:0]       kidx_q, kidx_d;
  byte_t            key_byte;

  localparam byte_t I_LAST = byte_t'(S_SIZE - 1);
  localparam logic [1:0] KIDX_LAST = 2'(KEY_LEN - 1);

  // kidx tracks i mod 3 alongside i so no divider is needed
  always_comb begin
    key_byte = key_q[23:16];
    case (kidx_q)
      2'd1:    key_byte = key_q[15:8];
      2'd2:    key_byte = key_q[7:0];
      default: key_byte = key_q[23:16];
    endcase
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    key_d   = key_q;
    kidx_d  = kidx_q;
    address = '0;
    data    = '0;
    wren    = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          key_d   = secret_key;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = INIT;
        end
      end
      INIT: begin
        address = i_q;
        data    = i_q;
        wren    = 1'b1;
        i_d     = i_q + 8'd1;
        if (i_q == I_LAST) state_d = RD_I;
      end
      RD_I: begin
        address = i_q;
        state_d = WT_I;
      end
      WT_I: begin
        address = i_q;
        si_d    = q;
        state_d = CALC_J;
      end
      CALC_J: begin
        j_d     = j_q + si_q + key_byte;
        state_d = RD_J;
      end
      RD_J: begin
        address = j_q;
        state_d = WT_J;
      end
      WT_J: begin
        address = j_q;
        sj_d    = q;
        state_d = WR_I;
      end
      WR_I: begin
        address = i_q;
        data    = sj_q;
        wren    = 1'b1;
        state_d = WR_J;
      end
      // when i==j this second write lands on the same word with the same value
      WR_J: begin
        address = j_q;
        data    = si_q;
        wren    = 1'b1;
        if (i_q == I_LAST) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == KIDX_LAST) ? 2'd0 : kidx_q + 2'd1;
          state_d = RD_I;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      key_q   <= '0;
      kidx_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
      kidx_q  <= kidx_d;
    end
  end

endmodule
